// File: rtl/game_scan_if.sv
// Beam/strobe bundle from game_scan_timing to its consumer.
// The frame_cnt signal exists only when GAME_SCAN_FRAME_CNT_EN is defined.
interface game_scan_if;
    logic       hsync;
    logic       vsync;
    logic [7:0] sx;
    logic [8:0] sy;
    logic       display_enabled;
    logic       game_pix_stb;
    logic       frame_stb;
`ifdef GAME_SCAN_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    modport master (
        output hsync, vsync, sx, sy, display_enabled, game_pix_stb, frame_stb,
        output frame_cnt
    );
    modport slave (
        input hsync, vsync, sx, sy, display_enabled, game_pix_stb, frame_stb,
        input frame_cnt
    );
`else
    modport master (
        output hsync, vsync, sx, sy, display_enabled, game_pix_stb, frame_stb
    );
    modport slave (
        input hsync, vsync, sx, sy, display_enabled, game_pix_stb, frame_stb
    );
`endif
endinterface

// File: rtl/game_scan_timing.sv
// VGA raster generator mapped onto a centred, integer-upscaled game window.
// Produces hsync/vsync plus game beam coordinates and strobes, all registered
// one clock after the raster position they describe.
// Optional macro GAME_SCAN_FRAME_CNT_EN adds a 16-bit frame counter output.
module game_scan_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned GAME_W    = 224,
    parameter int unsigned GAME_H    = 288,
    parameter int unsigned SCALE     = 1
) (
    input  logic         vga_pix_clk,
    input  logic         rst_n,
    game_scan_if.master  scan
);

    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_OFFSET  = (H_VISIBLE - GAME_W * SCALE) / 2;
    localparam int unsigned V_OFFSET  = (V_VISIBLE - GAME_H * SCALE) / 2;
    localparam int unsigned H_WIN_END = H_OFFSET + GAME_W * SCALE;
    localparam int unsigned V_WIN_END = V_OFFSET + GAME_H * SCALE;
    localparam int unsigned HS_START  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END    = HS_START + H_SYNC;
    localparam int unsigned VS_START  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END    = VS_START + V_SYNC;
    localparam int unsigned HC_W      = $clog2(H_TOTAL);
    localparam int unsigned VC_W      = $clog2(V_TOTAL);
    localparam int unsigned SUB_W     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned SX_W      = 8;
    localparam int unsigned SY_W      = 9;
    localparam int unsigned FC_W      = 16;

    // Raster and sub-pixel state, describing the current physical position
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [VC_W-1:0]  vc_q, vc_d;
    logic [SUB_W-1:0] subx_q, subx_d;
    logic [SUB_W-1:0] suby_q, suby_d;
    logic [SX_W-1:0]  gx_q, gx_d;
    logic [SY_W-1:0]  gy_q, gy_d;

    // Registered outputs
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic [SX_W-1:0] sx_q, sx_d;
    logic [SY_W-1:0] sy_q, sy_d;
    logic            de_q, de_d;
    logic            pix_stb_q, pix_stb_d;
    logic            frame_stb_q, frame_stb_d;

    logic line_end;
    logic in_win_x;
    logic in_win_y;

    // Raster counters and sub-pixel / game-pixel tracking for the next position
    always_comb begin
        hc_d   = hc_q;
        vc_d   = vc_q;
        subx_d = subx_q;
        suby_d = suby_q;
        gx_d   = gx_q;
        gy_d   = gy_q;

        line_end = (hc_q == HC_W'(H_TOTAL - 1));
        in_win_x = (hc_q >= HC_W'(H_OFFSET)) && (hc_q < HC_W'(H_WIN_END));
        in_win_y = (vc_q >= VC_W'(V_OFFSET)) && (vc_q < VC_W'(V_WIN_END));

        if (line_end) begin
            hc_d = '0;
            vc_d = (vc_q == VC_W'(V_TOTAL - 1)) ? '0 : vc_q + VC_W'(1);
        end else begin
            hc_d = hc_q + HC_W'(1);
        end

        // Horizontal: restart at the window's left edge, step inside it
        if (hc_d == HC_W'(H_OFFSET)) begin
            subx_d = '0;
            gx_d   = '0;
        end else if (in_win_x) begin
            if (subx_q == SUB_W'(SCALE - 1)) begin
                subx_d = '0;
                if (gx_q != SX_W'(GAME_W - 1)) begin
                    gx_d = gx_q + SX_W'(1);
                end
            end else begin
                subx_d = subx_q + SUB_W'(1);
            end
        end

        // Vertical: only moves on line ends; restart at the window's top edge
        if (line_end) begin
            if (vc_d == VC_W'(V_OFFSET)) begin
                suby_d = '0;
                gy_d   = '0;
            end else if (in_win_y) begin
                if (suby_q == SUB_W'(SCALE - 1)) begin
                    suby_d = '0;
                    if (gy_q != SY_W'(GAME_H - 1)) begin
                        gy_d = gy_q + SY_W'(1);
                    end
                end else begin
                    suby_d = suby_q + SUB_W'(1);
                end
            end
        end
    end

    // Output decode of the current position, registered below
    always_comb begin
        hsync_d     = 1'b1;
        vsync_d     = 1'b1;
        de_d        = 1'b0;
        sx_d        = '0;
        sy_d        = '0;
        pix_stb_d   = 1'b0;
        frame_stb_d = 1'b0;

        if ((hc_q >= HC_W'(HS_START)) && (hc_q < HC_W'(HS_END))) begin
            hsync_d = 1'b0;
        end
        if ((vc_q >= VC_W'(VS_START)) && (vc_q < VC_W'(VS_END))) begin
            vsync_d = 1'b0;
        end

        de_d = in_win_x && in_win_y;
        if (de_d) begin
            sx_d      = gx_q;
            sy_d      = gy_q;
            pix_stb_d = (subx_q == '0) && (suby_q == '0);
        end
        frame_stb_d = (hc_q == HC_W'(H_OFFSET)) && (vc_q == VC_W'(V_OFFSET));
    end

    // State and output registers
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q        <= '0;
            vc_q        <= '0;
            subx_q      <= '0;
            suby_q      <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            sx_q        <= '0;
            sy_q        <= '0;
            de_q        <= 1'b0;
            pix_stb_q   <= 1'b0;
            frame_stb_q <= 1'b0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            subx_q      <= subx_d;
            suby_q      <= suby_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            de_q        <= de_d;
            pix_stb_q   <= pix_stb_d;
            frame_stb_q <= frame_stb_d;
        end
    end

    assign scan.hsync           = hsync_q;
    assign scan.vsync           = vsync_q;
    assign scan.sx              = sx_q;
    assign scan.sy              = sy_q;
    assign scan.display_enabled = de_q;
    assign scan.game_pix_stb    = pix_stb_q;
    assign scan.frame_stb       = frame_stb_q;

`ifdef GAME_SCAN_FRAME_CNT_EN
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

    // Counts frames on the same edge that raises frame_stb
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_stb_d) begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
    end

    // Frame counter register
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign scan.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_game_scan_timing.sv
// Directed bench for game_scan_timing: one full-geometry instance (SCALE=1)
// and two reduced-geometry instances (SCALE=1 and SCALE=2) on a shared clock,
// checked against a closed-form raster model.
module tb_game_scan_timing;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       stb;
        logic       fs;
        logic [7:0] sx;
        logic [8:0] sy;
    } obs_t;

    localparam obs_t RST_EXP = {1'b1, 1'b1, 3'b000, 8'd0, 9'd0};

    // Reduced geometry: 56 clk/line, 27 lines/frame, 1512 clk/frame
    localparam int BHV = 40, BHF = 4, BHS = 6, BHB = 6;
    localparam int BVV = 20, BVF = 2, BVS = 2, BVB = 3;
    localparam int BGW = 8,  BGH = 6;
    localparam int BFRAME = 56 * 27;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    game_scan_if if_a ();
    game_scan_if if_b ();
    game_scan_if if_c ();

    game_scan_timing u_a (
        .vga_pix_clk (clk),
        .rst_n       (rst_n),
        .scan        (if_a)
    );

    game_scan_timing #(
        .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
        .GAME_W(BGW), .GAME_H(BGH), .SCALE(1)
    ) u_b (
        .vga_pix_clk (clk),
        .rst_n       (rst_n),
        .scan        (if_b)
    );

    game_scan_timing #(
        .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
        .GAME_W(BGW), .GAME_H(BGH), .SCALE(2)
    ) u_c (
        .vga_pix_clk (clk),
        .rst_n       (rst_n),
        .scan        (if_c)
    );

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = {if_a.hsync, if_a.vsync, if_a.display_enabled, if_a.game_pix_stb,
                    if_a.frame_stb, if_a.sx, if_a.sy};
    assign obs_b = {if_b.hsync, if_b.vsync, if_b.display_enabled, if_b.game_pix_stb,
                    if_b.frame_stb, if_b.sx, if_b.sy};
    assign obs_c = {if_c.hsync, if_c.vsync, if_c.display_enabled, if_c.game_pix_stb,
                    if_c.frame_stb, if_c.sx, if_c.sy};

    int errors = 0;
    int checks = 0;
    int k = 0;
    int p = -1;
    int mis_a = 0, mis_b = 0, mis_c = 0;
    int mis_fc = 0;
    int fc_model = 0;

    // Expected outputs for raster position pos of a given geometry
    function automatic obs_t model(input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb,
                                   input int gw, input int gh, input int s, input int pos);
        obs_t e;
        int ht, vt, hc, vc, ho, vo;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        hc = pos % ht;
        vc = (pos / ht) % vt;
        ho = (hv - gw * s) / 2;
        vo = (vv - gh * s) / 2;
        e = RST_EXP;
        e.hs = !(hc >= hv + hf && hc < hv + hf + hs);
        e.vs = !(vc >= vv + vf && vc < vv + vf + vs);
        e.de = (hc >= ho) && (hc < ho + gw * s) && (vc >= vo) && (vc < vo + gh * s);
        if (e.de) begin
            e.sx  = 8'((hc - ho) / s);
            e.sy  = 9'((vc - vo) / s);
            e.stb = ((hc - ho) % s == 0) && ((vc - vo) % s == 0);
        end
        e.fs = (hc == ho) && (vc == vo);
        return e;
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge describe position p
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        p = k - 1;
        if (obs_a !== model(640, 16, 96, 48, 480, 10, 2, 33, 224, 288, 1, p)) mis_a++;
        if (obs_b !== model(BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, BGW, BGH, 1, p)) mis_b++;
        if (obs_c !== model(BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, BGW, BGH, 2, p)) mis_c++;
`ifdef GAME_SCAN_FRAME_CNT_EN
        if (obs_b.fs) fc_model = (fc_model + 1) % 65536;
        if (int'(if_b.frame_cnt) != fc_model) mis_fc++;
`endif
    endtask

    initial begin
        int first_hs_a, hs_cnt_a, first_fs_a;
        int sx_last_a, sy_last_a, de_after_a, sx_after_a;
        int fs_cnt_b, de_cnt_b, vs_low_b, sx_last_b, sy_last_b;
        int de_after_b, sx_after_b, sy_after_b;
        int stb_cnt_c, de_cnt_c;
        int first_fs_b2, first_fs_c2, first_hs_a2, waited;
        first_hs_a = -1; hs_cnt_a = 0; first_fs_a = -1;
        sx_last_a = -1; sy_last_a = -1; de_after_a = -1; sx_after_a = -1;
        fs_cnt_b = 0; de_cnt_b = 0; vs_low_b = 0; sx_last_b = -1; sy_last_b = -1;
        de_after_b = -1; sx_after_b = -1; sy_after_b = -1;
        stb_cnt_c = 0; de_cnt_c = 0;
        first_fs_b2 = -1; first_fs_c2 = -1; first_hs_a2 = -1;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("reset_a", obs_a, RST_EXP);
        chk("reset_b", obs_b, RST_EXP);
        chk("reset_c", obs_c, RST_EXP);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;

        // First frame of the full raster up to just past line 96 of the window
        for (int i = 0; i < 77300; i++) begin
            tick();
            if (!obs_a.hs && first_hs_a < 0) first_hs_a = p;
            if (p < 800 && !obs_a.hs) hs_cnt_a++;
            if (obs_a.fs && first_fs_a < 0) first_fs_a = p;
            if (p == 77231) begin sx_last_a = int'(obs_a.sx); sy_last_a = int'(obs_a.sy); end
            if (p == 77232) begin de_after_a = int'(obs_a.de); sx_after_a = int'(obs_a.sx); end
            if (p < 2 * BFRAME) begin
                fs_cnt_b  += int'(obs_b.fs);
                de_cnt_b  += int'(obs_b.de);
                stb_cnt_c += int'(obs_c.stb);
                de_cnt_c  += int'(obs_c.de);
            end
            if (p < BFRAME && !obs_b.vs) vs_low_b++;
            if (p == 695) begin sx_last_b = int'(obs_b.sx); sy_last_b = int'(obs_b.sy); end
            if (p == 696) begin
                de_after_b = int'(obs_b.de); sx_after_b = int'(obs_b.sx); sy_after_b = int'(obs_b.sy);
            end
        end

        chk("a_first_hsync_low_pos", first_hs_a, 656);
        chk("a_hsync_low_clks_line0", hs_cnt_a, 96);
        chk("a_first_frame_stb_pos", first_fs_a, 96 * 800 + 208);
        chk("a_last_px_line_sx", sx_last_a, 223);
        chk("a_last_px_line_sy", sy_last_a, 0);
        chk("a_after_window_de", de_after_a, 0);
        chk("a_after_window_sx", sx_after_a, 0);
        chk("b_frame_stb_2frames", fs_cnt_b, 2);
        chk("b_de_2frames", de_cnt_b, 2 * 48);
        chk("b_vsync_low_clks", vs_low_b, 2 * 56);
        chk("b_last_window_sx", sx_last_b, 7);
        chk("b_last_window_sy", sy_last_b, 5);
        chk("b_after_last_de", de_after_b, 0);
        chk("b_after_last_sx", sx_after_b, 0);
        chk("b_after_last_sy", sy_after_b, 0);
        chk("c_pix_stb_2frames", stb_cnt_c, 2 * 48);
        chk("c_de_2frames", de_cnt_c, 2 * 192);

        // Advance to a mid-window point of the reduced raster (hc 20, vc 10)
        waited = 0;
        while ((p % BFRAME) != 10 * 56 + 20 && waited < BFRAME + 2) begin
            tick();
            waited++;
        end
        chk("wait_midframe_bound", int'(waited < BFRAME + 2), 1);
        chk("b_pre_reset_de", obs_b.de, 1'b1);
        chk("b_pre_reset_sx", obs_b.sx, 4);
        chk("b_pre_reset_sy", obs_b.sy, 3);

        // Mid-frame asynchronous reset held for 3 clocks
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", obs_a, RST_EXP);
        chk("async_reset_b", obs_b, RST_EXP);
        chk("async_reset_c", obs_c, RST_EXP);
        repeat (3) @(posedge clk);
        #1;
        chk("held_reset_b", obs_b, RST_EXP);
        chk("held_reset_c", obs_c, RST_EXP);
`ifdef GAME_SCAN_FRAME_CNT_EN
        chk("held_reset_frame_cnt", if_b.frame_cnt, 0);
        fc_model = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;

        for (int i = 0; i < 2 * BFRAME + 100; i++) begin
            tick();
            if (obs_b.fs && first_fs_b2 < 0) first_fs_b2 = p;
            if (obs_c.fs && first_fs_c2 < 0) first_fs_c2 = p;
            if (!obs_a.hs && first_hs_a2 < 0) first_hs_a2 = p;
        end
        chk("b_first_frame_stb_after_reset", first_fs_b2, 7 * 56 + 16);
        chk("c_first_frame_stb_after_reset", first_fs_c2, 4 * 56 + 12);
        chk("a_first_hsync_after_reset", first_hs_a2, 656);

        chk("a_model_mismatch_cycles", mis_a, 0);
        chk("b_model_mismatch_cycles", mis_b, 0);
        chk("c_model_mismatch_cycles", mis_c, 0);
`ifdef GAME_SCAN_FRAME_CNT_EN
        chk("b_frame_cnt_mismatch_cycles", mis_fc, 0);
        chk("b_frame_cnt_value", if_b.frame_cnt, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
